// File: rtl/vga_timing_if.sv
// ============================================================================
// Module      : vga_timing_if
// Description : Raster coordinate, blank and sync bundle between the timing
//               generator and the pixel stages. frame_count exists only when
//               VGA_FRAME_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface vga_timing_if;
   logic [9:0] DrawX;
   logic [9:0] DrawY;
   logic       blank;
   logic       hs;
   logic       vs;
   logic       frame_start;
   logic       line_start;
`ifdef VGA_FRAME_CNT_EN
   logic [7:0] frame_count;
`endif

   modport master (
`ifdef VGA_FRAME_CNT_EN
      output frame_count,
`endif
      output DrawX, DrawY, blank, hs, vs, frame_start, line_start
   );

   modport slave (
`ifdef VGA_FRAME_CNT_EN
      input  frame_count,
`endif
      input  DrawX, DrawY, blank, hs, vs, frame_start, line_start
   );
endinterface

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA raster timing generator (coordinates, blank, hs/vs, line
//               and frame pulses). Optional 8-bit frame counter when
//               VGA_FRAME_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module vga_timing_gen #(
   parameter int unsigned H_VISIBLE = 640,
   parameter int unsigned H_FRONT   = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_BACK    = 48,
   parameter int unsigned V_VISIBLE = 480,
   parameter int unsigned V_FRONT   = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_BACK    = 33,
   parameter bit          SYNC_POL  = 1'b0
) (
   input  wire logic    vga_clk,
   input  wire logic    reset_n,
   vga_timing_if.master vga
);

   // Totals are limited to 1024, so region bounds may reach 1024 and are held in 11 bits.
   localparam logic [9:0]  c_h_last     = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
   localparam logic [9:0]  c_v_last     = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
   localparam logic [10:0] c_h_vis_end  = 11'(H_VISIBLE);
   localparam logic [10:0] c_h_sync_beg = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] c_h_sync_end = 11'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [10:0] c_v_vis_end  = 11'(V_VISIBLE);
   localparam logic [10:0] c_v_sync_beg = 11'(V_VISIBLE + V_FRONT);
   localparam logic [10:0] c_v_sync_end = 11'(V_VISIBLE + V_FRONT + V_SYNC);

   logic [9:0] r_hc;
   logic [9:0] r_vc;
   logic       r_blank;
   logic       r_hs;
   logic       r_vs;
   logic       r_frame_start;
   logic       r_line_start;

   logic       w_h_wrap;
   logic [9:0] w_hc_next;
   logic [9:0] w_vc_next;
   logic       w_visible;
   logic       w_hs_act;
   logic       w_vs_act;
   logic       w_line_wrap;
   logic       w_frame_wrap;

   // Flags are decoded from the next counts so they land with the coordinates they describe.
   always_comb begin
      w_h_wrap     = (r_hc == c_h_last);
      w_hc_next    = w_h_wrap ? 10'd0 : r_hc + 10'd1;
      w_vc_next    = r_vc;
      if (w_h_wrap) begin
         w_vc_next = (r_vc == c_v_last) ? 10'd0 : r_vc + 10'd1;
      end
      w_visible    = ({1'b0, w_hc_next} < c_h_vis_end) && ({1'b0, w_vc_next} < c_v_vis_end);
      w_hs_act     = ({1'b0, w_hc_next} >= c_h_sync_beg) && ({1'b0, w_hc_next} < c_h_sync_end);
      w_vs_act     = ({1'b0, w_vc_next} >= c_v_sync_beg) && ({1'b0, w_vc_next} < c_v_sync_end);
      w_line_wrap  = (w_hc_next == 10'd0);
      w_frame_wrap = w_line_wrap && (w_vc_next == 10'd0);
   end

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_hc          <= 10'd0;
         r_vc          <= 10'd0;
         r_blank       <= 1'b0;
         r_hs          <= ~SYNC_POL;
         r_vs          <= ~SYNC_POL;
         r_frame_start <= 1'b0;
         r_line_start  <= 1'b0;
      end else begin
         r_hc          <= w_hc_next;
         r_vc          <= w_vc_next;
         r_blank       <= w_visible;
         r_hs          <= w_hs_act ? SYNC_POL : ~SYNC_POL;
         r_vs          <= w_vs_act ? SYNC_POL : ~SYNC_POL;
         r_frame_start <= w_frame_wrap;
         r_line_start  <= w_line_wrap;
      end
   end

   assign vga.DrawX       = r_hc;
   assign vga.DrawY       = r_vc;
   assign vga.blank       = r_blank;
   assign vga.hs          = r_hs;
   assign vga.vs          = r_vs;
   assign vga.frame_start = r_frame_start;
   assign vga.line_start  = r_line_start;

`ifdef VGA_FRAME_CNT_EN
   logic [7:0] r_frame_count;

   always_ff @(posedge vga_clk or negedge reset_n) begin
      if (!reset_n) begin
         r_frame_count <= 8'd0;
      end else if (w_frame_wrap) begin
         r_frame_count <= r_frame_count + 8'd1;
      end
   end

   assign vga.frame_count = r_frame_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen: a default 640x480
//               instance and a small, positive-sync instance for frame-level
//               behaviour. Covers frame_count when VGA_FRAME_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_gen;

   localparam int SHV = 8, SHF = 2, SHS = 3, SHB = 3;
   localparam int SVV = 6, SVF = 2, SVS = 2, SVB = 2;
   localparam int SHT = SHV + SHF + SHS + SHB;
   localparam int SFRAME = SHT * (SVV + SVF + SVS + SVB);

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       blank;
      logic       hs;
      logic       vs;
      logic       fs;
      logic       ls;
   } vstate_t;

   logic vga_clk = 1'b0;
   logic rstn_d  = 1'b0;
   logic rstn_s  = 1'b0;
   int   td      = 0;
   int   ts      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 vga_clk = ~vga_clk;

   vga_timing_if vd ();
   vga_timing_if vsi ();

   vga_timing_gen dut_d (
      .vga_clk (vga_clk),
      .reset_n (rstn_d),
      .vga     (vd)
   );

   vga_timing_gen #(
      .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
      .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
      .SYNC_POL (1'b1)
   ) dut_s (
      .vga_clk (vga_clk),
      .reset_n (rstn_s),
      .vga     (vsi)
   );

   // Edges seen since each reset release: the model's time base.
   always @(posedge vga_clk or negedge rstn_d) if (!rstn_d) td <= 0; else td <= td + 1;
   always @(posedge vga_clk or negedge rstn_s) if (!rstn_s) ts <= 0; else ts <= ts + 1;

   // Position is simply elapsed pixels modulo the frame; flags come from region bounds.
   function automatic vstate_t model(int t, int hv, int hf, int hsw, int hb,
                                     int vv, int vf, int vsw, int vb, bit pol);
      vstate_t e;
      int ht, vt, p, x, y;
      ht = hv + hf + hsw + hb;
      vt = vv + vf + vsw + vb;
      if (t == 0) begin
         e = '{x: 10'd0, y: 10'd0, blank: 1'b0, hs: !pol, vs: !pol, fs: 1'b0, ls: 1'b0};
         return e;
      end
      p = t % (ht * vt);
      x = p % ht;
      y = p / ht;
      e.x     = 10'(x);
      e.y     = 10'(y);
      e.blank = (x < hv) && (y < vv);
      e.hs    = (x >= hv + hf && x < hv + hf + hsw) ? pol : !pol;
      e.vs    = (y >= vv + vf && y < vv + vf + vsw) ? pol : !pol;
      e.fs    = (p == 0);
      e.ls    = (x == 0);
      return e;
   endfunction

   function automatic vstate_t model_d(int t);
      return model(t, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
   endfunction

   function automatic vstate_t model_s(int t);
      return model(t, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1);
   endfunction

   function automatic vstate_t get_d();
      return {vd.DrawX, vd.DrawY, vd.blank, vd.hs, vd.vs, vd.frame_start, vd.line_start};
   endfunction

   function automatic vstate_t get_s();
      return {vsi.DrawX, vsi.DrawY, vsi.blank, vsi.hs, vsi.vs, vsi.frame_start, vsi.line_start};
   endfunction

   task automatic test_reset();
      rstn_d = 1'b0;
      rstn_s = 1'b0;
      repeat (5) @(posedge vga_clk);
      @(negedge vga_clk);
      n_checks++;
      if (get_d() !== model_d(0)) $display("FAIL reset_default got=%h exp=%h", get_d(), model_d(0));
      else n_pass++;
      n_checks++;
      if (get_s() !== model_s(0)) $display("FAIL reset_small got=%h exp=%h", get_s(), model_s(0));
      else n_pass++;
      rstn_d = 1'b1;
      rstn_s = 1'b1;
      @(negedge vga_clk);
      n_checks++;
      if (vd.DrawX !== 10'd1 || vd.DrawY !== 10'd0 || vd.blank !== 1'b1)
         $display("FAIL first_edge got x=%0d y=%0d blank=%b exp x=1 y=0 blank=1", vd.DrawX, vd.DrawY, vd.blank);
      else n_pass++;
   endtask

   task automatic test_line();
      int hs_cnt = 0;
      for (int i = 0; i < 801; i++) begin
         n_checks++;
         if (get_d() !== model_d(td)) $display("FAIL line t=%0d got=%h exp=%h", td, get_d(), model_d(td));
         else n_pass++;
         if (vd.hs == 1'b0 && vd.DrawY == 10'd0) hs_cnt++;
         @(negedge vga_clk);
      end
      n_checks++;
      if (hs_cnt !== 96) $display("FAIL hs_width got=%0d exp=96", hs_cnt);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int k = 0;
      while (vd.DrawX !== 10'd700 && k < 900) begin
         @(negedge vga_clk);
         k++;
      end
      n_checks++;
      if (vd.DrawX !== 10'd700 || vd.hs !== 1'b0)
         $display("FAIL reach_x700 got x=%0d hs=%b exp x=700 hs=0", vd.DrawX, vd.hs);
      else n_pass++;
      #1 rstn_d = 1'b0;
      #1;
      n_checks++;
      if (get_d() !== model_d(0)) $display("FAIL async_reset got=%h exp=%h", get_d(), model_d(0));
      else n_pass++;
      repeat (2) @(negedge vga_clk);
      rstn_d = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge vga_clk);
         n_checks++;
         if (get_d() !== model_d(td) || vd.DrawX !== 10'(i + 1))
            $display("FAIL restart t=%0d got=%h exp=%h", td, get_d(), model_d(td));
         else n_pass++;
      end
   endtask

   task automatic test_frame();
      int vs_cnt = 0, bl_cnt = 0, fs_cnt = 0, ls_cnt = 0;
      rstn_s = 1'b0;
      @(negedge vga_clk);
      rstn_s = 1'b1;
      for (int i = 0; i < SFRAME; i++) begin
         @(negedge vga_clk);
         n_checks++;
         if (get_s() !== model_s(ts)) $display("FAIL frame t=%0d got=%h exp=%h", ts, get_s(), model_s(ts));
         else n_pass++;
         vs_cnt += int'(vsi.vs);
         bl_cnt += int'(vsi.blank);
         fs_cnt += int'(vsi.frame_start);
         ls_cnt += int'(vsi.line_start);
      end
      n_checks++;
      if (vs_cnt !== SVS * SHT) $display("FAIL vs_width got=%0d exp=%0d", vs_cnt, SVS * SHT);
      else n_pass++;
      n_checks++;
      if (bl_cnt !== SHV * SVV) $display("FAIL visible_count got=%0d exp=%0d", bl_cnt, SHV * SVV);
      else n_pass++;
      n_checks++;
      if (fs_cnt !== 1 || ls_cnt !== 12)
         $display("FAIL pulse_counts got fs=%0d ls=%0d exp fs=1 ls=12", fs_cnt, ls_cnt);
      else n_pass++;
   endtask

   task automatic test_frame_wrap();
      int k = 0;
      while (!(vsi.DrawX == 10'(SHT - 1) && vsi.DrawY == 10'd11) && k < 2 * SFRAME) begin
         @(negedge vga_clk);
         k++;
      end
      n_checks++;
      if (vsi.DrawX !== 10'(SHT - 1) || vsi.DrawY !== 10'd11)
         $display("FAIL reach_last got x=%0d y=%0d exp x=%0d y=11", vsi.DrawX, vsi.DrawY, SHT - 1);
      else n_pass++;
      @(negedge vga_clk);
      n_checks++;
      if (vsi.DrawX !== 10'd0 || vsi.DrawY !== 10'd0 || vsi.frame_start !== 1'b1 || vsi.line_start !== 1'b1)
         $display("FAIL wrap got x=%0d y=%0d fs=%b ls=%b exp 0 0 1 1",
                  vsi.DrawX, vsi.DrawY, vsi.frame_start, vsi.line_start);
      else n_pass++;
      @(negedge vga_clk);
      n_checks++;
      if (vsi.DrawX !== 10'd1 || vsi.frame_start !== 1'b0 || vsi.line_start !== 1'b0)
         $display("FAIL after_wrap got x=%0d fs=%b ls=%b exp 1 0 0", vsi.DrawX, vsi.frame_start, vsi.line_start);
      else n_pass++;
   endtask

   task automatic test_random();
      for (int it = 0; it < 12; it++) begin
         int run = int'($urandom_range(1, 400));
         for (int i = 0; i < run; i++) begin
            @(negedge vga_clk);
            n_checks++;
            if (get_s() !== model_s(ts)) $display("FAIL random t=%0d got=%h exp=%h", ts, get_s(), model_s(ts));
            else n_pass++;
         end
         if ($urandom_range(0, 1) == 1) begin
            #($urandom_range(1, 3)) rstn_s = 1'b0;
            #1;
            n_checks++;
            if (get_s() !== model_s(0)) $display("FAIL random_reset got=%h exp=%h", get_s(), model_s(0));
            else n_pass++;
            repeat ($urandom_range(1, 3)) @(negedge vga_clk);
            rstn_s = 1'b1;
         end
      end
   endtask

`ifdef VGA_FRAME_CNT_EN
   task automatic test_frame_count();
      logic [7:0] exp_fc;
      rstn_s = 1'b0;
      @(negedge vga_clk);
      n_checks++;
      if (vsi.frame_count !== 8'd0) $display("FAIL fc_reset got=%0d exp=0", vsi.frame_count);
      else n_pass++;
      rstn_s = 1'b1;
      for (int i = 0; i < 256 * SFRAME + 2; i++) begin
         @(negedge vga_clk);
         exp_fc = 8'((ts / SFRAME) % 256);
         if (vsi.frame_start || (ts % 48) == 0) begin
            n_checks++;
            if (vsi.frame_count !== exp_fc) $display("FAIL frame_count t=%0d got=%0d exp=%0d", ts, vsi.frame_count, exp_fc);
            else n_pass++;
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_line();
      test_reset_mid();
      test_frame();
      test_frame_wrap();
      test_random();
`ifdef VGA_FRAME_CNT_EN
      test_frame_count();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
